// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encoding, tag prefix,
// default end-of-packet byte and the tag-byte helper.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAG  = 2'd1,
        ST_XFER = 2'd2
    } arb_state_e;

    localparam logic [7:0] TAG_PREFIX  = 8'hF0;
    localparam logic [7:0] EOP_DEFAULT = 8'h0A;

    // Tag byte announcing which source owns the following bytes.
    function automatic logic [7:0] tag_byte(input logic [3:0] idx);
        return TAG_PREFIX | {4'h0, idx};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first requesting index
// found searching upward from last_i+1 (modulo N), plus a valid flag.
module uart_tx_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  req_rdy_i,
    input  logic [GW-1:0] last_i,
    output logic [GW-1:0] next_o,
    output logic          valid_o
);

    // Scan from the farthest candidate down to the nearest so the nearest wins.
    always_comb begin
        int idx;
        idx     = 0;
        next_o  = '0;
        valid_o = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last_i) + k) % N;
            if (req_rdy_i[GW'(idx)]) begin
                next_o  = GW'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N FIFO byte sources.
// Optional feature macro: UART_ARB_TAG_EN -- when defined, every grant is
// preceded by a tag byte 8'hF0 | grant on the wire.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int         N     = 4,
    parameter int         BURST = 16,
    parameter logic [7:0] EOP   = EOP_DEFAULT,
    parameter int         GW    = $clog2(N),
    parameter int         CW    = $clog2(BURST + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_rdy,
    input  logic [8*N-1:0]  req_data,
    output logic [N-1:0]    req_fetch,
    output logic            tx_rdy,
    output logic [7:0]      tx_data,
    input  logic            tx_fetch,
    output logic [GW-1:0]   grant,
    output logic            busy
);

    arb_state_e    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [7:0]    src_byte [N];
    logic [7:0]    head_byte;
    logic          src_rdy;
    logic          accept;
    logic [GW-1:0] pick_idx;
    logic          pick_valid;

    // Split the flat data bus into one byte per source.
    for (genvar gi = 0; gi < N; gi++) begin : g_src
        assign src_byte[gi] = req_data[8*gi +: 8];
    end

    assign head_byte = src_byte[grant_q];
    assign src_rdy   = req_rdy[grant_q];
    assign grant     = grant_q;

    uart_tx_arbiter_rr_pick #(
        .N  (N),
        .GW (GW)
    ) u_pick (
        .req_rdy_i (req_rdy),
        .last_i    (grant_q),
        .next_o    (pick_idx),
        .valid_o   (pick_valid)
    );

    // State, grant and burst counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= GW'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and handshake routing between granted FIFO and uart_tx.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        tx_rdy    = 1'b0;
        tx_data   = 8'h00;
        req_fetch = '0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
`ifdef UART_ARB_TAG_EN
                    state_d = ST_TAG;
`else
                    state_d = ST_XFER;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                busy    = 1'b1;
                tx_rdy  = 1'b1;
                tx_data = tag_byte(4'(grant_q));
                if (tx_fetch) begin
                    state_d = ST_XFER;
                end
            end
`endif
            ST_XFER: begin
                busy    = 1'b1;
                tx_rdy  = src_rdy;
                tx_data = head_byte;
                accept  = tx_fetch & src_rdy;
                if (accept) begin
                    req_fetch[grant_q] = 1'b1;
                    cnt_d              = cnt_q + 1'b1;
                end
                // A fetch with nothing presented is ignored and does not
                // count as the source draining either.
                if (accept && ((head_byte == EOP) || (cnt_q == CW'(BURST - 1)))) begin
                    state_d = ST_IDLE;
                end else if (!src_rdy && !tx_fetch) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
